// File: rtl/seg7_scan_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | seg7_scan_ctrl_if : control/value inputs and decoder/anode outputs of     |
// |                     the 7-segment scan controller.   Rev 1.0             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface seg7_scan_ctrl_if #(
  parameter int NDIG = 8
);
  logic                run;
  logic [4*NDIG-1:0]   iVALUE;
  logic [NDIG-1:0]     iBLANK_MASK;
  logic                iLZB;
  logic [3:0]          oDIG;
  logic                oLUT_EN;
  logic [NDIG-1:0]     oAN;
  logic                oFRAME;

  modport master (
    output run, iVALUE, iBLANK_MASK, iLZB,
    input  oDIG, oLUT_EN, oAN, oFRAME
  );

  modport slave (
    input  run, iVALUE, iBLANK_MASK, iLZB,
    output oDIG, oLUT_EN, oAN, oFRAME
  );
endinterface

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// +--------------------------------------------------------------------------+
// | seg7_scan_ctrl : multiplexed common-anode display scanner feeding one     |
// |                  shared registered hex-to-7seg decoder.   Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module seg7_scan_ctrl #(
  parameter int NDIG  = 8,
  parameter int DWELL = 1024,
  parameter int GUARD = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  seg7_scan_ctrl_if.slave   bus
);

  localparam int c_TMAX = (GUARD > DWELL) ? GUARD : DWELL;
  localparam int c_TW   = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;
  localparam int c_IW   = $clog2(NDIG);

  localparam logic [c_TW-1:0] c_GUARD_LAST = c_TW'(GUARD - 1);
  localparam logic [c_TW-1:0] c_DWELL_LAST = c_TW'(DWELL - 1);
  localparam logic [c_IW-1:0] c_IDX_LAST   = c_IW'(NDIG - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_GUARD = 2'd2,
    ST_SHOW  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_IW-1:0]   r_idx;
  logic [c_IW-1:0]   w_idx_nxt;
  logic [c_TW-1:0]   r_timer;
  logic [c_TW-1:0]   w_timer_nxt;

  logic [4*NDIG-1:0] r_snap_val;
  logic [NDIG-1:0]   r_snap_mask;
  logic              r_snap_lzb;

  logic [3:0]        r_dig;
  logic              r_lut_en;
  logic [NDIG-1:0]   r_an;
  logic              r_frame;

  logic              w_capture;
  logic [3:0]        w_load_nib;
  logic [NDIG-1:0]   w_blank;
  logic [NDIG-1:0]   w_an_nxt;

  // Sequencing; dropping run overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_timer_nxt = r_timer;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.run) begin
          w_state_nxt = ST_LOAD;
          w_idx_nxt   = '0;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_GUARD;
        w_timer_nxt = '0;
      end
      ST_GUARD: begin
        if (r_timer == c_GUARD_LAST) begin
          w_state_nxt = ST_SHOW;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_SHOW: begin
        if (r_timer == c_DWELL_LAST) begin
          w_state_nxt = ST_LOAD;
          w_timer_nxt = '0;
          w_idx_nxt   = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!bus.run) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_timer_nxt = '0;
    end
  end

  // A frame starts whenever digit 0 is about to be loaded.
  assign w_capture  = (w_state_nxt == ST_LOAD) && (w_idx_nxt == '0);
  assign w_load_nib = w_capture ? bus.iVALUE[3:0] : r_snap_val[4*w_idx_nxt +: 4];

  always_comb begin
    for (int k = 0; k < NDIG; k++) begin
      w_blank[k] = r_snap_mask[k] |
                   (r_snap_lzb && (k != 0) && ((r_snap_val >> (4*k)) == '0));
    end
  end

  always_comb begin
    w_an_nxt = '1;
    if ((w_state_nxt == ST_SHOW) && !w_blank[w_idx_nxt]) begin
      w_an_nxt[w_idx_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_timer     <= '0;
      r_snap_val  <= '0;
      r_snap_mask <= '0;
      r_snap_lzb  <= 1'b0;
      r_dig       <= 4'h0;
      r_lut_en    <= 1'b0;
      r_an        <= '1;
      r_frame     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_timer  <= w_timer_nxt;
      if (w_capture) begin
        r_snap_val  <= bus.iVALUE;
        r_snap_mask <= bus.iBLANK_MASK;
        r_snap_lzb  <= bus.iLZB;
      end
      if (w_state_nxt == ST_LOAD) begin
        r_dig <= w_load_nib;
      end
      r_lut_en <= (w_state_nxt == ST_LOAD);
      r_an     <= w_an_nxt;
      r_frame  <= w_capture;
    end
  end

  assign bus.oDIG    = r_dig;
  assign bus.oLUT_EN = r_lut_en;
  assign bus.oAN     = r_an;
  assign bus.oFRAME  = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_seg7_scan_ctrl : randomized bench for seg7_scan_ctrl against a         |
// |                     frame-position reference model.   Rev 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seg7_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int GUARD = 1;
  localparam int DWELL = 4;
  localparam int P     = 1 + GUARD + DWELL;
  localparam int FRAME = NDIG * P;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  seg7_scan_ctrl_if #(.NDIG(NDIG)) bus ();

  seg7_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .GUARD(GUARD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: position within the frame since the last (re)start.
  bit              m_active;
  int              m_n;
  logic [15:0]     m_val;
  logic [NDIG-1:0] m_mask;
  bit              m_lzb;
  logic [3:0]      e_dig;
  logic [NDIG-1:0] e_an;
  logic            e_lut;
  logic            e_frame;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit blanked(input int d);
    return m_mask[d] || (m_lzb && d != 0 && (m_val >> (4*d)) == 16'h0);
  endfunction

  task automatic model_reset();
    m_active = 0; m_n = 0; m_val = '0; m_mask = '0; m_lzb = 0;
    e_dig = 4'h0; e_an = '1; e_lut = 1'b0; e_frame = 1'b0;
  endtask

  task automatic model_edge();
    int d, ph;
    if (!bus.run) begin
      m_active = 0;
      e_an = '1; e_lut = 1'b0; e_frame = 1'b0;
    end else begin
      if (!m_active) begin
        m_active = 1;
        m_n = 0;
      end else begin
        m_n = (m_n + 1) % FRAME;
      end
      if (m_n == 0) begin
        m_val = bus.iVALUE; m_mask = bus.iBLANK_MASK; m_lzb = bus.iLZB;
      end
      d  = m_n / P;
      ph = m_n % P;
      e_lut   = (ph == 0);
      e_frame = (ph == 0) && (d == 0);
      if (ph == 0) e_dig = m_val[4*d +: 4];
      e_an = '1;
      if (ph > GUARD && !blanked(d)) e_an[d] = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("dig",     32'(bus.oDIG),    32'(e_dig));
    check("an",      32'(bus.oAN),     32'(e_an));
    check("lut_en",  32'(bus.oLUT_EN), 32'(e_lut));
    check("frame",   32'(bus.oFRAME),  32'(e_frame));
    check("an_1hot", 32'($countones(~bus.oAN) <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until(input int target);
    int budget = 2 * FRAME + 2;
    while (!(m_active && m_n == target) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("sync_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bus.run = 1'b0; bus.iVALUE = '0; bus.iBLANK_MASK = '0; bus.iLZB = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(2);

    // Plain digits
    bus.iVALUE = 16'h1234; bus.run = 1'b1;
    run_cycles(2 * FRAME);

    // Asynchronous reset while digit 1 is lit
    run_until(P + GUARD + 2);
    #2 rst_n = 1'b0;
    #1;
    check("rst_an",    32'(bus.oAN),     32'hF);
    check("rst_lut",   32'(bus.oLUT_EN), 32'd0);
    check("rst_frame", 32'(bus.oFRAME),  32'd0);
    check("rst_dig",   32'(bus.oDIG),    32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycles(FRAME);

    // Input change mid-frame must not tear the frame
    run_until(2 * P);
    bus.iVALUE = 16'h5678;
    run_cycles(FRAME + P);

    // Leading-zero blanking
    bus.iLZB = 1'b1; bus.iVALUE = 16'h0070;
    run_cycles(2 * FRAME);
    bus.iVALUE = 16'h0000;
    run_cycles(2 * FRAME);

    // Per-digit mask
    bus.iLZB = 1'b0; bus.iBLANK_MASK = 4'b0100; bus.iVALUE = 16'hABCD;
    run_cycles(2 * FRAME);
    bus.iBLANK_MASK = '0;

    // Drop run in digit 1's guard interval, then restart
    run_until(P + 1);
    bus.run = 1'b0;
    run_cycles(5);
    bus.run = 1'b1;
    run_cycles(FRAME);

    // Randomized segments
    for (int s = 0; s < 40; s++) begin
      int len;
      bus.iVALUE      = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      bus.iBLANK_MASK = ($urandom_range(0, 3) == 0) ? NDIG'($urandom) : '0;
      bus.iLZB        = 1'($urandom);
      len = $urandom_range(1, 3 * FRAME);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 7) == 0)  bus.iVALUE = 16'($urandom);
        if ($urandom_range(0, 19) == 0) bus.run = ~bus.run;
        tick();
      end
      bus.run = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
